ipd_dac_tx: RTL and testbench
=============================

Name: ipd_dac_tx

Overview:
- Actuator-side companion to the I-PD controller.
- Generates the periodic `listo` sample strobe that starts each controller computation.
- After the controller's fixed latency it captures the 22-bit `suma` result, scales and saturates it to 12 bits, and shifts it out as a 16-bit SPI frame to an MCP4921-class DAC.
- Together with the ADC front end, this closes the sampled control loop.

Parameters:
- PERIODO, 100: clock cycles per sample period; `listo` repeats at this interval.
- LATENCIA, 16: clock edges from controller strobe to valid `suma`.
- SHIFT, 8: arithmetic right shift applied to `suma` before saturation.
- DIV_SCLK, 2: `sclk` half-period in clk cycles (`sclk` = clk/(2*DIV_SCLK)).
- Legal range: PERIODO > LATENCIA + 4 + 34*DIV_SCLK. The default, 100 > 88, is legal; an illegal value is an elaboration error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  loop enable.
- listo  out  1  one-cycle sample strobe to controller and ADC.
- suma  in  22  signed two's-complement controller output.
- dato_dac  out  12  last captured, saturated DAC code.
- sat  out  1  last capture was clamped.
- busy  out  1  SPI frame in progress (cs_n low or end hold).
- overrun  out  1  sticky: a capture arrived while busy.
- cs_n  out  1  DAC chip select, active low.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data, MSB first.

Behaviour:
- Reset (synchronous, rst=1 at an edge) is dominant at any time, including mid-frame; the frame is aborted with no partial completion.
  - listo=0, cs_n=1, sclk=0, mosi=0, busy=0, sat=0, overrun=0, dato_dac=0.
  - All counters return to 0 and the FSM returns to IDLE.
- Period counter `cnt` (0..PERIODO-1):
  - At an edge with en=1 and cnt==0: listo<=1 and cnt<=1.
  - Otherwise with en=1: cnt increments, wrapping PERIODO-1 -> 0, and listo<=0.
  - en=0: cnt<=0 and listo<=0, so the first strobe appears one edge after en returns.
- Latency counter:
  - Armed by the edge that asserts listo.
  - `suma` is captured at the (LATENCIA+1)-th edge after that edge, i.e. LATENCIA edges after the controller sampled listo.
  - A capture already armed still occurs if en drops.
- Capture arithmetic:
  - v = suma >>> SHIFT (sign-extended).
  - v<0 -> code 0, sat=1.
  - v>4095 -> code 4095, sat=1.
  - Otherwise code = v[11:0], sat=0.
  - dato_dac and sat update at the capture edge.
- Frame format: frame = {4'b0011, code}, 16 bits (A/B=0, BUF=0, GA_n=1, SHDN_n=1).
- SPI FSM:
  - IDLE: cs_n=1, busy=0. On capture, load the shift register, cs_n<=0, busy<=1 -> SETUP.
  - SETUP: mosi=frame[15]; hold DIV_SCLK cycles -> SHIFT.
  - SHIFT:
    - sclk toggles every DIV_SCLK cycles, 16 rising edges in total.
    - mosi changes only on sclk falling edges and is stable at each rising edge.
    - After the 16th falling edge, sclk=0 -> HOLD.
  - HOLD: cs_n<=1, held 2*DIV_SCLK cycles with busy=1 -> IDLE.
- Capture while busy (only possible with a future illegal override): the new capture still updates dato_dac/sat, the frame in flight continues unchanged, the new code is not sent, and overrun<=1 (cleared only by rst).
- Simultaneous events: listo assertion and a capture in the same edge are independent and both take effect.

Decomposition:
- Package ipd_dac_pkg holds:
  - FRAME_W=16, DAC_W=12, SUMA_W=22.
  - DAC_HDR=4'b0011.
  - FSM state encoding {IDLE, SETUP, SHIFT, HOLD}.
- Natural sub-module: spi_dac_ser, the shift register, sclk divider and FSM, with a start/code/busy interface.
- Timing, capture and saturation remain in ipd_dac_tx.

Test Plan:
- rst, en=1 with default parameters -> listo pulses exactly one cycle every 100 cycles; the first pulse is one edge after rst deasserts.
- suma=22'h0ABCDE held -> capture at LATENCIA+1 edges after listo; dato_dac=12'hABC, sat=0; the DAC model decodes 16'h3ABC over 16 sclk rising edges with sclk period 4 clk.
- suma=22'h3FFF00 (-256) -> dato_dac=0, sat=1, frame 16'h3000.
- suma=22'h100000 -> v=4096, dato_dac=12'hFFF, sat=1, frame 16'h3FFF.
- Mid-frame reset: assert rst on the 8th sclk rising edge -> cs_n=1, sclk=0 and busy=0 the next cycle; the DAC model latches nothing.
- Toggle en=0 for 250 cycles mid-run -> no listo while low; the in-flight frame completes normally; overrun stays 0 throughout.

Source files
------------

// File: rtl/ipd_dac_pkg.sv
// Shared widths, DAC frame header, serializer state encoding and the
// scale/saturate helper for the I-PD actuator path.
package ipd_dac_pkg;

  localparam int FRAME_W = 16;
  localparam int DAC_W   = 12;
  localparam int SUMA_W  = 22;

  // A/B=0 (channel A), BUF=0, GA_n=1 (1x gain), SHDN_n=1 (active)
  localparam logic [3:0] DAC_HDR = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } ser_state_t;

  // Returns {sat, code}: negative values clamp to 0, values above the
  // 12-bit range clamp to full scale.
  function automatic logic [DAC_W:0] sat_code(input logic [SUMA_W-1:0] v);
    if (v[SUMA_W-1])
      return {1'b1, {DAC_W{1'b0}}};
    else if (|v[SUMA_W-2:DAC_W])
      return {1'b1, {DAC_W{1'b1}}};
    else
      return {1'b0, v[DAC_W-1:0]};
  endfunction

endpackage

// File: rtl/ipd_dac_tx_spi.sv
// SPI serializer for an MCP4921-class DAC: shift register, sclk divider and
// frame sequencing FSM behind a start/code/busy handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | cs_n high, waiting for start
//   ST_SETUP | cs_n low, MSB on mosi, waiting before the first sclk rise
//   ST_SHIFT | sclk toggling; mosi advances on each falling edge
//   ST_HOLD  | cs_n high again (DAC latches), busy held before idle
module spi_dac_ser
  import ipd_dac_pkg::*;
#(
  parameter int DIV_SCLK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DAC_W-1:0] i_code,
  output logic             o_busy,
  output logic             o_cs_n,
  output logic             o_sclk,
  output logic             o_mosi
);

  localparam int DIV_W = $clog2(2*DIV_SCLK + 1);

  ser_state_t         r_state;
  logic [FRAME_W-1:0] r_sr;
  logic [DIV_W-1:0]   r_div;
  logic [3:0]         r_bit;
  logic [FRAME_W-1:0] w_frame;

  assign w_frame = {DAC_HDR, i_code};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      o_busy  <= 1'b0;
      o_cs_n  <= 1'b1;
      o_sclk  <= 1'b0;
      o_mosi  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sr    <= w_frame;
            o_mosi  <= w_frame[FRAME_W-1];
            o_cs_n  <= 1'b0;
            o_busy  <= 1'b1;
            r_div   <= DIV_W'(DIV_SCLK - 1);
            r_bit   <= 4'd15;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_div == '0) begin
            o_sclk  <= 1'b1;
            r_div   <= DIV_W'(DIV_SCLK - 1);
            r_state <= ST_SHIFT;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (r_div == '0) begin
            r_div <= DIV_W'(DIV_SCLK - 1);
            if (o_sclk) begin
              o_sclk <= 1'b0;
              // r_bit counts falling edges still to come; zero means this is the 16th
              if (r_bit == 4'd0) begin
                o_cs_n  <= 1'b1;
                o_mosi  <= 1'b0;
                r_div   <= DIV_W'(2*DIV_SCLK - 1);
                r_state <= ST_HOLD;
              end else begin
                r_bit  <= r_bit - 4'd1;
                r_sr   <= {r_sr[FRAME_W-2:0], 1'b0};
                o_mosi <= r_sr[FRAME_W-2];
              end
            end else begin
              o_sclk <= 1'b1;
            end
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_div == '0) begin
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_div <= r_div - DIV_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ipd_dac_tx.sv
// Sample strobe generator, latency-aligned capture of the controller output,
// scale/saturate to a 12-bit DAC code, and hand-off to the SPI serializer.
module ipd_dac_tx
  import ipd_dac_pkg::*;
#(
  parameter int PERIODO  = 100,
  parameter int LATENCIA = 16,
  parameter int SHIFT    = 8,
  parameter int DIV_SCLK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              listo,
  input  logic [SUMA_W-1:0] suma,
  output logic [DAC_W-1:0]  dato_dac,
  output logic              sat,
  output logic              busy,
  output logic              overrun,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi
);

  // A whole frame plus capture latency must fit inside one sample period
  if (PERIODO <= LATENCIA + 4 + 34*DIV_SCLK) begin : g_bad_periodo
    $error("ipd_dac_tx: PERIODO too small for LATENCIA and DIV_SCLK");
  end

  localparam int CNT_W = $clog2(PERIODO);
  localparam int LAT_W = $clog2(LATENCIA + 2);

  logic [CNT_W-1:0]         r_cnt;
  logic [LAT_W-1:0]         r_lat;
  logic                     w_strobe;
  logic                     w_capture;
  logic signed [SUMA_W-1:0] w_scaled;
  logic [DAC_W:0]           w_sat_code;

  assign w_strobe   = en && (r_cnt == '0);
  assign w_capture  = (r_lat == LAT_W'(1));
  assign w_scaled   = $signed(suma) >>> SHIFT;
  assign w_sat_code = sat_code(w_scaled);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_lat    <= '0;
      listo    <= 1'b0;
      dato_dac <= '0;
      sat      <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (!en) begin
        r_cnt <= '0;
        listo <= 1'b0;
      end else if (w_strobe) begin
        r_cnt <= CNT_W'(1);
        listo <= 1'b1;
      end else begin
        listo <= 1'b0;
        r_cnt <= (r_cnt == CNT_W'(PERIODO - 1)) ? '0 : r_cnt + CNT_W'(1);
      end

      // Armed capture keeps running even if en drops afterwards
      if (w_strobe)
        r_lat <= LAT_W'(LATENCIA + 1);
      else if (r_lat != '0)
        r_lat <= r_lat - LAT_W'(1);

      if (w_capture) begin
        sat      <= w_sat_code[DAC_W];
        dato_dac <= w_sat_code[DAC_W-1:0];
        if (busy)
          overrun <= 1'b1;
      end
    end
  end

  spi_dac_ser #(
    .DIV_SCLK(DIV_SCLK)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_capture),
    .i_code (w_sat_code[DAC_W-1:0]),
    .o_busy (busy),
    .o_cs_n (cs_n),
    .o_sclk (sclk),
    .o_mosi (mosi)
  );

endmodule

// File: tb/tb_ipd_dac_tx.sv
// Bench for ipd_dac_tx: DAC-side SPI model feeding a frame scoreboard, plus
// strobe period and capture-timing checks against hand-computed values.
module tb_ipd_dac_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [21:0] suma;
  logic        listo, sat, busy, overrun, cs_n, sclk, mosi;
  logic [11:0] dato_dac;

  typedef struct {
    logic [15:0] frame;
    logic [11:0] code;
    logic        sat;
  } exp_t;

  exp_t q[$];
  exp_t e_pop;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_frames = 0;
  int n_aborted = 0;
  int bit_cnt = 0;
  int last_rise = -1;
  int last_listo = -1;
  logic [15:0] shreg = '0;
  logic per_bad = 1'b0;
  logic prev_csn = 1'b1;
  logic prev_sclk = 1'b0;
  logic prev_listo = 1'b0;

  ipd_dac_tx dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .listo   (listo),
    .suma    (suma),
    .dato_dac(dato_dac),
    .sat     (sat),
    .busy    (busy),
    .overrun (overrun),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .mosi    (mosi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] f, input logic [11:0] c, input logic s);
    exp_t e;
    e.frame = f;
    e.code  = c;
    e.sat   = s;
    q.push_back(e);
  endtask

  // DAC model and scoreboard monitor
  always @(negedge clk) begin
    if (!prev_csn && cs_n) begin
      if (bit_cnt == 16) begin
        n_frames++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h expected none", shreg);
        end else begin
          e_pop = q.pop_front();
          chk("frame", 32'(shreg), 32'(e_pop.frame));
          chk("frame_dato_dac", 32'(dato_dac), 32'(e_pop.code));
          chk("frame_sat", 32'(sat), 32'(e_pop.sat));
          chk("sclk_period_ok", 32'(per_bad), 32'd0);
        end
      end else if (bit_cnt != 0) begin
        n_aborted++;
      end
    end
    if (prev_csn && !cs_n) begin
      bit_cnt   = 0;
      shreg     = '0;
      last_rise = -1;
      per_bad   = 1'b0;
    end
    if (!cs_n && !prev_sclk && sclk) begin
      shreg = {shreg[14:0], mosi};
      bit_cnt++;
      if (last_rise >= 0 && (cyc - last_rise) != 4) per_bad = 1'b1;
      last_rise = cyc;
    end
    prev_csn  = cs_n;
    prev_sclk = sclk;
  end

  // Strobe width and period checker
  always @(negedge clk) begin
    if (prev_listo) chk("listo_width", 32'(listo), 32'd0);
    if (listo === 1'b1) begin
      if (last_listo >= 0) chk("listo_period", 32'(cyc - last_listo), 32'd100);
      last_listo = cyc;
    end
    prev_listo = listo;
  end

  task automatic wait_listo(input int budget);
    int n = 0;
    while (listo !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("listo_timeout", 32'(listo), 32'd1);
  endtask

  task automatic wait_frames(input int k, input int budget);
    int n = 0;
    while (n_frames < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 32'(n_frames >= k), 32'd1);
  endtask

  task automatic wait_rises(input int k, input int budget);
    int n = 0;
    while (!(bit_cnt == k && cs_n === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rise_timeout", 32'(bit_cnt == k), 32'd1);
  endtask

  // Called at the negedge right after the strobe edge
  task automatic check_capture(input logic [11:0] old_code, input logic [11:0] new_code,
                               input logic new_sat);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("pre_capture_code", 32'(dato_dac), 32'(old_code));
    @(negedge clk);
    chk("capture_code", 32'(dato_dac), 32'(new_code));
    chk("capture_sat", 32'(sat), 32'(new_sat));
    chk("busy_at_capture", 32'(busy), 32'd1);
    chk("cs_n_at_capture", 32'(cs_n), 32'd0);
  endtask

  initial begin
    int n_listo_low;
    logic ovr_seen;

    rst  = 1'b1;
    en   = 1'b0;
    suma = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_listo", 32'(listo), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_dato_dac", 32'(dato_dac), 32'd0);

    // In-range value: 0x0ABCDE >>> 8 = 0xABC
    en   = 1'b1;
    suma = 22'h0ABCDE;
    push(16'h3ABC, 12'hABC, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("first_listo", 32'(listo), 32'd1);
    check_capture(12'h000, 12'hABC, 1'b0);
    wait_frames(1, 200);

    // -256 >>> 8 = -1 clamps to 0
    suma = 22'h3FFF00;
    push(16'h3000, 12'h000, 1'b1);
    wait_listo(200);
    check_capture(12'hABC, 12'h000, 1'b1);
    wait_frames(2, 200);

    // 0x100000 >>> 8 = 4096 clamps to full scale
    suma = 22'h100000;
    push(16'h3FFF, 12'hFFF, 1'b1);
    wait_listo(200);
    check_capture(12'h000, 12'hFFF, 1'b1);
    wait_frames(3, 200);

    // Reset in the middle of a frame
    suma = 22'h0ABCDE;
    wait_rises(8, 300);
    rst = 1'b1;
    last_listo = -1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dato_dac", 32'(dato_dac), 32'd0);
    rst = 1'b0;
    push(16'h3ABC, 12'hABC, 1'b0);
    repeat (20) @(negedge clk);
    chk("no_partial_frame", 32'(n_frames), 32'd3);
    chk("aborted_frames", 32'(n_aborted), 32'd1);
    wait_frames(4, 300);

    // Drop en just after a strobe; the armed capture and its frame still complete
    suma = 22'h07FF00;
    push(16'h37FF, 12'h7FF, 1'b0);
    wait_listo(200);
    repeat (5) @(negedge clk);
    en = 1'b0;
    n_listo_low = 0;
    ovr_seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (listo === 1'b1) n_listo_low++;
      if (overrun !== 1'b0) ovr_seen = 1'b1;
    end
    chk("listo_while_en_low", 32'(n_listo_low), 32'd0);
    chk("overrun_while_en_low", 32'(ovr_seen), 32'd0);
    chk("frame_done_while_en_low", 32'(n_frames), 32'd5);
    last_listo = -1;
    en = 1'b1;
    push(16'h37FF, 12'h7FF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("listo_after_en", 32'(listo), 32'd1);
    wait_frames(6, 200);
    repeat (20) @(negedge clk);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("overrun_final", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
